// File: rtl/systolic_feeder_2x2.sv
// Front-end sequencer for a 2x2 output-stationary array:
// latches A/B, clears, feeds skewed streams, drains, captures C.
module systolic_feeder_2x2 #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a00,
  input  logic [WIDTH-1:0] a01,
  input  logic [WIDTH-1:0] a10,
  input  logic [WIDTH-1:0] a11,
  input  logic [WIDTH-1:0] b00,
  input  logic [WIDTH-1:0] b01,
  input  logic [WIDTH-1:0] b10,
  input  logic [WIDTH-1:0] b11,
  output logic             arr_clear,
  output logic [WIDTH-1:0] arr_a0,
  output logic [WIDTH-1:0] arr_a1,
  output logic [WIDTH-1:0] arr_b0,
  output logic [WIDTH-1:0] arr_b1,
  input  logic [WIDTH-1:0] arr_c00,
  input  logic [WIDTH-1:0] arr_c01,
  input  logic [WIDTH-1:0] arr_c10,
  input  logic [WIDTH-1:0] arr_c11,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c00,
  output logic [WIDTH-1:0] c01,
  output logic [WIDTH-1:0] c10,
  output logic [WIDTH-1:0] c11,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] DrainLast = 4'(DRAIN_CYCLES - 1);
  localparam logic [WIDTH-1:0] Zero = '0;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a00_q, a01_q, a10_q, a11_q;
  logic [WIDTH-1:0] b00_q, b01_q, b10_q, b11_q;
  logic             clr_q, ovld_q, rdy_q, busy_q;
  logic [WIDTH-1:0] sa0_q, sa1_q, sb0_q, sb1_q;
  logic [WIDTH-1:0] c00_q, c01_q, c10_q, c11_q;

  // Sequencer: every output is produced here as a register, so the
  // value seen in a cycle is the one chosen at the edge that began it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a00_q   <= '0;
      a01_q   <= '0;
      a10_q   <= '0;
      a11_q   <= '0;
      b00_q   <= '0;
      b01_q   <= '0;
      b10_q   <= '0;
      b11_q   <= '0;
      clr_q   <= 1'b0;
      ovld_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      sa0_q   <= '0;
      sa1_q   <= '0;
      sb0_q   <= '0;
      sb1_q   <= '0;
      c00_q   <= '0;
      c01_q   <= '0;
      c10_q   <= '0;
      c11_q   <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      ovld_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      sa0_q   <= '0;
      sa1_q   <= '0;
      sb0_q   <= '0;
      sb1_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a00_q   <= a00;
            a01_q   <= a01;
            a10_q   <= a10;
            a11_q   <= a11;
            b00_q   <= b00;
            b01_q   <= b01;
            b10_q   <= b10;
            b11_q   <= b11;
            clr_q   <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          clr_q   <= 1'b0;
          sa0_q   <= a00_q;
          sa1_q   <= Zero;
          sb0_q   <= b00_q;
          sb1_q   <= Zero;
          cnt_q   <= '0;
          state_q <= S_FEED;
        end
        S_FEED: begin
          // cnt_q is the step currently on the wires; load the next one.
          if (cnt_q == 4'd0) begin
            sa0_q <= a01_q;
            sa1_q <= a10_q;
            sb0_q <= b10_q;
            sb1_q <= b01_q;
            cnt_q <= 4'd1;
          end else if (cnt_q == 4'd1) begin
            sa0_q <= Zero;
            sa1_q <= a11_q;
            sb0_q <= Zero;
            sb1_q <= b11_q;
            cnt_q <= 4'd2;
          end else begin
            sa0_q   <= Zero;
            sa1_q   <= Zero;
            sb0_q   <= Zero;
            sb1_q   <= Zero;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DrainLast) begin
            c00_q   <= arr_c00;
            c01_q   <= arr_c01;
            c10_q   <= arr_c10;
            c11_q   <= arr_c11;
            ovld_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            ovld_q  <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign busy      = busy_q;
  assign arr_clear = clr_q;
  assign arr_a0    = sa0_q;
  assign arr_a1    = sa1_q;
  assign arr_b0    = sb0_q;
  assign arr_b1    = sb1_q;
  assign out_valid = ovld_q;
  assign c00       = c00_q;
  assign c01       = c01_q;
  assign c10       = c10_q;
  assign c11       = c11_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2: skew model from matrix indices,
// random operands/results, backpressure, async reset and abort.
module tb_systolic_feeder_2x2;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
  logic [W-1:0] b00 = '0, b01 = '0, b10 = '0, b11 = '0;
  logic         arr_clear;
  logic [W-1:0] arr_a0, arr_a1, arr_b0, arr_b1;
  logic [W-1:0] arr_c00 = '0, arr_c01 = '0, arr_c10 = '0, arr_c11 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] c00, c01, c10, c11;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] A [2][2];
  logic [W-1:0] B [2][2];
  logic [W-1:0] C [4];
  logic [W-1:0] exp_c [4];

  always #5 clk = ~clk;

  systolic_feeder_2x2 #(.WIDTH(W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .arr_clear(arr_clear),
    .arr_a0(arr_a0), .arr_a1(arr_a1),
    .arr_b0(arr_b0), .arr_b1(arr_b1),
    .arr_c00(arr_c00), .arr_c01(arr_c01),
    .arr_c10(arr_c10), .arr_c11(arr_c11),
    .out_valid(out_valid), .out_ready(out_ready),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .busy(busy)
  );

  task automatic rand_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        A[i][j] = 8'($urandom);
        B[i][j] = 8'($urandom);
      end
    for (int i = 0; i < 4; i++) C[i] = 8'($urandom);
  endtask

  task automatic drive_ops();
    a00 = A[0][0]; a01 = A[0][1]; a10 = A[1][0]; a11 = A[1][1];
    b00 = B[0][0]; b01 = B[0][1]; b10 = B[1][0]; b11 = B[1][1];
    arr_c00 = C[0]; arr_c01 = C[1]; arr_c10 = C[2]; arr_c11 = C[3];
  endtask

  task automatic scramble_ports();
    a00 = 8'($urandom); a01 = 8'($urandom);
    a10 = 8'($urandom); a11 = 8'($urandom);
    b00 = 8'($urandom); b01 = 8'($urandom);
    b10 = 8'($urandom); b11 = 8'($urandom);
  endtask

  // Positions at a negedge with in_ready high, or logs a timeout.
  task automatic wait_ready(input string tag, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s ready_timeout: in_ready=%b want 1", tag, in_ready);
    end
  endtask

  // Full transaction; stream expectations come from the skew rule:
  // row i carries A[i][t-i], column j carries B[t-j][j].
  task automatic run_txn(input string tag, input int bp);
    bit ok;
    int t;
    logic         eclr;
    logic [W-1:0] ea0, ea1, eb0, eb1;
    logic [35:0]  got, exp;
    logic [34:0]  got2, exp2;
    wait_ready(tag, ok);
    if (!ok) return;
    drive_ops();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_ports();
    for (int k = 1; k <= 4 + D; k++) begin
      @(negedge clk);
      t = k - 2;
      eclr = (k == 1);
      ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
      if (t >= 0 && t <= 2) begin
        if (t < 2) begin
          ea0 = A[0][t];
          eb0 = B[t][0];
        end
        if (t >= 1) begin
          ea1 = A[1][t-1];
          eb1 = B[t-1][1];
        end
      end
      got = {arr_clear, arr_a0, arr_a1, arr_b0, arr_b1,
             out_valid, in_ready, busy};
      exp = {eclr, ea0, ea1, eb0, eb1, 3'b001};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s stream_cyc%0d: got %h want %h",
                 tag, k, got, exp);
      end
      if (k >= 5) in_valid = 1'($urandom);
    end
    for (int j = 0; j <= bp; j++) begin
      @(negedge clk);
      got2 = {out_valid, in_ready, busy, c00, c01, c10, c11};
      exp2 = {3'b101, C[0], C[1], C[2], C[3]};
      n_chk++;
      if (got2 !== exp2) begin
        n_fail++;
        $display("FAIL %s result_hold%0d: got %h want %h",
                 tag, j, got2, exp2);
      end
      arr_c00 = 8'($urandom); arr_c01 = 8'($urandom);
      arr_c10 = 8'($urandom); arr_c11 = 8'($urandom);
      out_ready = (j == bp);
      in_valid  = (j < bp) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    got2 = {out_valid, in_ready, busy, c00, c01, c10, c11};
    exp2 = {3'b010, C[0], C[1], C[2], C[3]};
    n_chk++;
    if (got2 !== exp2) begin
      n_fail++;
      $display("FAIL %s after_handshake: got %h want %h",
               tag, got2, exp2);
    end
    for (int i = 0; i < 4; i++) exp_c[i] = C[i];
  endtask

  task automatic set_directed();
    A[0][0] = 8'h11; A[0][1] = 8'h12; A[1][0] = 8'h21; A[1][1] = 8'h22;
    B[0][0] = 8'h31; B[0][1] = 8'h32; B[1][0] = 8'h41; B[1][1] = 8'h42;
    C[0] = 8'hAA; C[1] = 8'hBB; C[2] = 8'hCC; C[3] = 8'hDD;
  endtask

  task automatic test_reset();
    logic [W*8+3:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {in_ready, busy, out_valid, arr_clear,
           arr_a0, arr_a1, arr_b0, arr_b1, c00, c01, c10, c11};
    n_chk++;
    if (got !== {4'b1000, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", got, {4'b1000, 64'h0});
    end
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
  endtask

  task automatic test_stream();
    set_directed();
    run_txn("stream", 0);
  endtask

  task automatic test_backpressure();
    rand_ops();
    run_txn("backpressure", 10);
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [W*8+3:0] got;
    rand_ops();
    wait_ready("async_rst", ok);
    if (!ok) return;
    drive_ops();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (arr_a1 !== A[1][0]) begin
      n_fail++;
      $display("FAIL async_rst feed_step1: got %h want %h", arr_a1, A[1][0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {in_ready, busy, out_valid, arr_clear,
           arr_a0, arr_a1, arr_b0, arr_b1, c00, c01, c10, c11};
    n_chk++;
    if (got !== {4'b1000, 64'h0}) begin
      n_fail++;
      $display("FAIL async_rst immediate: got %h want %h",
               got, {4'b1000, 64'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
    set_directed();
    run_txn("post_reset", 0);
  endtask

  task automatic test_abort();
    bit ok;
    logic [W*4+3:0] got;
    logic [W*4+3:0] exp;
    rand_ops();
    wait_ready("abort", ok);
    if (!ok) return;
    drive_ops();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    for (int k = 0; k < D + 4; k++) begin
      @(negedge clk);
      got = {out_valid, in_ready, busy, arr_clear, c00, c01, c10, c11};
      exp = {4'b0100, exp_c[0], exp_c[1], exp_c[2], exp_c[3]};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_drain%0d: got %h want %h", k, got, exp);
      end
    end
    abort    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({in_ready, busy, arr_clear} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 100",
               {in_ready, busy, arr_clear});
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      run_txn("b2b", int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_async_reset();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
- Front-end controller for the 2x2 FP8 output-stationary systolic array.
- Accepts one 2x2 A and one 2x2 B operand set via valid/ready.
- Pulses the array clear, then drives skewed row/column byte streams into the array's a_data/b_data inputs.
- Waits a fixed drain interval, captures the four array results, and presents them downstream via valid/ready.

Parameters:
WIDTH, 8, byte width of every operand/result element (FP8 encoding; block treats values as opaque bits)
DRAIN_CYCLES, 4, cycles of zero-feed after the last operand before results are sampled; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
abort  input  1  synchronous abort; returns the FSM to IDLE
in_valid  input  1  operand set valid
in_ready  output  1  block can accept an operand set
a00,a01,a10,a11  input  WIDTH each  matrix A elements (row,col)
b00,b01,b10,b11  input  WIDTH each  matrix B elements (row,col)
arr_clear  output  1  clear pulse to array accumulators
arr_a0,arr_a1  output  WIDTH each  row streams to array a_data0/a_data1
arr_b0,arr_b1  output  WIDTH each  column streams to array b_data0/b_data1
arr_c00,arr_c01,arr_c10,arr_c11  input  WIDTH each  array result outputs
out_valid  output  1  result set valid
out_ready  input  1  downstream accepts result
c00,c01,c10,c11  output  WIDTH each  captured results
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM=IDLE; all operand and result registers, arr_*, c*, out_valid, arr_clear = 0; in_ready=1.
  - Reset mid-operation discards all work. No output glitches after release.
- All outputs are registered. in_ready = (state==IDLE). busy = !in_ready.
- FSM states and transitions:
  - IDLE: on in_valid&&in_ready, latch A/B into internal registers; next state CLEAR.
  - CLEAR: 1 cycle. arr_clear=1, streams=0. Next state FEED, step counter=0.
  - FEED: 3 cycles, step t=0,1,2. arr_clear=0. Stream values per step:
    - arr_a0: t0=a00, t1=a01, t2=0
    - arr_a1: t0=0, t1=a10, t2=a11
    - arr_b0: t0=b00, t1=b10, t2=0
    - arr_b1: t0=0, t1=b01, t2=b11
    - After t=2, next state DRAIN, counter=0.
  - DRAIN: DRAIN_CYCLES cycles, streams=0. At the clock edge ending the last DRAIN cycle: c00..c11 <= arr_c00..arr_c11; out_valid<=1; next state DONE.
  - DONE: c* and out_valid held stable while out_ready=0. On out_valid&&out_ready, out_valid<=0; next state IDLE. in_ready is high the following cycle; no same-cycle re-accept.
- Timing: with acceptance in cycle 0, CLEAR is cycle 1, FEED is cycles 2–4, DRAIN is cycles 5..4+DRAIN_CYCLES, and out_valid is first high in cycle 5+DRAIN_CYCLES (9 at default).
- in_valid outside IDLE is ignored. Latched operands are immune to input changes after acceptance.
- abort:
  - Any state -> IDLE next cycle; streams/arr_clear/out_valid -> 0; c* retain their last values.
  - abort has priority over in_valid and out_ready in the same cycle. abort in IDLE is a no-op (no acceptance that cycle).
- Counters saturate only at their terminal state transitions; no wrap within a transaction.

Test Plan:
- Reset -> in_ready=1, busy=0, out_valid=0, arr_* all 0x00, c* all 0x00.
- Stream check: A=[11,12;21,22], B=[31,32;41,42] (hex), accepted in cycle 0:
  - cycle 1: arr_clear=1, streams 00.
  - cycle 2: a0=11, a1=00, b0=31, b1=00.
  - cycle 3: a0=12, a1=21, b0=41, b1=32.
  - cycle 4: a0=00, a1=22, b0=00, b1=42.
  - cycles 5–8: streams 00.
- Capture/latency: bench holds arr_c=AA,BB,CC,DD, out_ready=1 -> out_valid high cycle 9 only; c00..c11=AA,BB,CC,DD; in_ready high cycle 10.
- Backpressure: out_ready=0 for 10 cycles from out_valid -> out_valid and c* stable; in_ready=0; in_valid pulses ignored. Raise out_ready -> handshake; IDLE next cycle.
- rst_n low asynchronously during FEED step 1 -> outputs 0x00 immediately without waiting for a clock edge; after release the next transaction repeats the exact stream-check sequence.
- abort during DRAIN -> IDLE next cycle, out_valid never asserts, prior c* retained. abort together with in_valid in IDLE -> not accepted.
